// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_pkg : shared multiplier width and operand-loader state encoding |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mult_pkg;

   localparam int MULT_W = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ser2par_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser2par_lane : indexed-bit serial capture register with restart      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ser2par_lane
   import mult_pkg::*;
#(
   parameter int WIDTH     = MULT_W,
   parameter bit LSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture,
   input  logic             restart,
   input  logic [CW-1:0]    idx,
   input  logic             bit_in,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    w_pos;

   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_pos = idx;
      end else begin : g_msb_first
         assign w_pos = CW'(WIDTH - 1) - idx;
      end
   endgenerate

   // word includes the bit being sampled this cycle, so a completing frame
   // can be transferred to the output register without an extra cycle.
   always_comb begin
      word        = restart ? '0 : r_shift;
      word[w_pos] = bit_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (capture) begin
         r_shift <= word;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mult_operand_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_operand_deser : two-lane serial operand loader with valid/ready |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mult_operand_deser
   import mult_pkg::*;
#(
   parameter int WIDTH     = MULT_W,
   parameter bit LSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_pad,
   input  logic             a_pad,
   input  logic             b_pad,
   input  logic             op_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             op_valid,
   output logic             busy,
   output logic             overrun
);

   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_idx;
   logic             w_capture;
   logic             w_last;
   logic             w_accept;
   logic             w_load;
   logic             w_drop;
   logic [WIDTH-1:0] w_a_word;
   logic [WIDTH-1:0] w_b_word;
   logic [WIDTH-1:0] r_a_out;
   logic [WIDTH-1:0] r_b_out;
   logic             r_op_valid;
   logic             r_overrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (frame_pad) begin
               w_capture    = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            w_capture = 1'b1;
            if (!frame_pad && (r_count == C_LAST)) begin
               w_last       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A frame strobe always forces the current bit to index 0.
   assign w_idx = frame_pad ? '0 : r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_capture) begin
         if (frame_pad) begin
            r_count <= CW'(1);
         end else if (w_last) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   ser2par_lane #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_lane_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (w_capture),
      .restart (frame_pad),
      .idx     (w_idx),
      .bit_in  (a_pad),
      .word    (w_a_word)
   );

   ser2par_lane #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_lane_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (w_capture),
      .restart (frame_pad),
      .idx     (w_idx),
      .bit_in  (b_pad),
      .word    (w_b_word)
   );

   // The output slot is free if empty or being consumed in this same cycle.
   assign w_accept = !r_op_valid || op_ready;
   assign w_load   = w_last && w_accept;
   assign w_drop   = w_last && !w_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_out    <= '0;
         r_b_out    <= '0;
         r_op_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_load) begin
            r_a_out    <= w_a_word;
            r_b_out    <= w_b_word;
            r_op_valid <= 1'b1;
         end else if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign a_out    = r_a_out;
   assign b_out    = r_b_out;
   assign op_valid = r_op_valid;
   assign overrun  = r_overrun;
   assign busy     = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_operand_deser : directed bench, LSB-first and MSB-first DUTs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mult_operand_deser;

   logic        clk = 1'b0;
   logic        rst_n, frame_pad, a_pad, b_pad, op_ready, ovr_clr;
   logic [15:0] a_out, b_out, ra_out, rb_out;
   logic        op_valid, busy, overrun, rop_valid, rbusy, roverrun;

   int n_chk  = 0;
   int n_fail = 0;
   int n_acc  = 0;

   always #5 clk = ~clk;

   mult_operand_deser #(.WIDTH(16), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .frame_pad(frame_pad), .a_pad(a_pad), .b_pad(b_pad),
      .op_ready(op_ready), .ovr_clr(ovr_clr), .a_out(a_out), .b_out(b_out),
      .op_valid(op_valid), .busy(busy), .overrun(overrun)
   );

   mult_operand_deser #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .frame_pad(frame_pad), .a_pad(a_pad), .b_pad(b_pad),
      .op_ready(op_ready), .ovr_clr(ovr_clr), .a_out(ra_out), .b_out(rb_out),
      .op_valid(rop_valid), .busy(rbusy), .overrun(roverrun)
   );

   always @(posedge clk) if (op_valid && op_ready) n_acc <= n_acc + 1;

   typedef struct {
      logic [15:0] a;       // serial order: a[i] is sent in frame cycle i
      logic [15:0] b;
      logic [15:0] exp_a;   // LSB-first result
      logic [15:0] exp_b;
      logic [15:0] exp_ra;  // MSB-first result
      logic [15:0] exp_rb;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one full frame; returns op_valid as seen during the last bit cycle.
   task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic rdy_body, input logic rdy_last,
                             output logic valid_at_last);
      valid_at_last = 1'b0;
      for (int i = 0; i < 16; i++) begin
         frame_pad = (i == 0);
         a_pad     = a[i];
         b_pad     = b[i];
         op_ready  = (i == 15) ? rdy_last : rdy_body;
         if (i == 15) valid_at_last = op_valid;
         tick();
      end
      frame_pad = 1'b0;
      a_pad     = 1'b0;
      b_pad     = 1'b0;
   endtask

   logic v15;
   int   acc0;

   initial begin
      vecs[0] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 16'h2C48, 16'hB3D5};
      vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
      vecs[2] = '{16'hA5A5, 16'h0F0F, 16'hA5A5, 16'h0F0F, 16'hA5A5, 16'hF0F0};
      vecs[3] = '{16'h8001, 16'h0001, 16'h8001, 16'h0001, 16'h8001, 16'h8000};
      vecs[4] = '{16'h0001, 16'h7FFE, 16'h0001, 16'h7FFE, 16'h8000, 16'h7FFE};

      rst_n = 1'b0; frame_pad = 1'b0; a_pad = 1'b0; b_pad = 1'b0;
      op_ready = 1'b0; ovr_clr = 1'b0;
      tick(); tick();
      chk("reset a_out", a_out, 0);
      chk("reset b_out", b_out, 0);
      chk("reset op_valid", op_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset overrun", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Table: each frame accepted immediately, valid for exactly one cycle.
      for (int k = 0; k < 5; k++) begin
         send_frame(vecs[k].a, vecs[k].b, 1'b1, 1'b1, v15);
         chk($sformatf("vec%0d valid before done", k), v15, 0);
         chk($sformatf("vec%0d op_valid", k), op_valid, 1);
         chk($sformatf("vec%0d a_out", k), a_out, vecs[k].exp_a);
         chk($sformatf("vec%0d b_out", k), b_out, vecs[k].exp_b);
         chk($sformatf("vec%0d msb a_out", k), ra_out, vecs[k].exp_ra);
         chk($sformatf("vec%0d msb b_out", k), rb_out, vecs[k].exp_rb);
         chk($sformatf("vec%0d busy idle", k), busy, 0);
         op_ready = 1'b1;
         tick();
         chk($sformatf("vec%0d consumed", k), op_valid, 0);
         chk($sformatf("vec%0d overrun", k), overrun, 0);
      end

      // Back-pressure: second frame dropped, overrun sticky; set beats clear.
      send_frame(16'h0001, 16'h0002, 1'b0, 1'b0, v15);
      chk("bp first valid", op_valid, 1);
      chk("bp first overrun", overrun, 0);
      send_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, v15);
      chk("bp held a_out", a_out, 16'h0001);
      chk("bp held b_out", b_out, 16'h0002);
      chk("bp held valid", op_valid, 1);
      chk("bp overrun set", overrun, 1);
      ovr_clr = 1'b1;
      tick();
      chk("ovr_clr clears", overrun, 0);
      send_frame(16'h5555, 16'h5555, 1'b0, 1'b0, v15);
      chk("set wins over clear", overrun, 1);
      chk("bp still held a_out", a_out, 16'h0001);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr again", overrun, 0);
      op_ready = 1'b1;
      tick();
      chk("bp drained", op_valid, 0);

      // Same-cycle consume and complete.
      send_frame(16'h00AA, 16'h0055, 1'b0, 1'b0, v15);
      chk("cc first valid", op_valid, 1);
      send_frame(16'h1111, 16'h2222, 1'b0, 1'b1, v15);
      chk("cc op_valid", op_valid, 1);
      chk("cc a_out", a_out, 16'h1111);
      chk("cc b_out", b_out, 16'h2222);
      chk("cc overrun", overrun, 0);
      op_ready = 1'b1;
      tick();
      chk("cc drained", op_valid, 0);

      // Restart at bit 7: partial frame silently discarded.
      acc0 = n_acc;
      op_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         frame_pad = (i == 0); a_pad = 1'b1; b_pad = 1'b1;
         tick();
      end
      chk("restart busy", busy, 1);
      send_frame(16'hBEEF, 16'hCAFE, 1'b1, 1'b1, v15);
      chk("restart no early valid", v15, 0);
      chk("restart a_out", a_out, 16'hBEEF);
      chk("restart b_out", b_out, 16'hCAFE);
      tick();
      chk("restart one pair", n_acc - acc0, 1);
      chk("restart overrun", overrun, 0);

      // Reset at bit 9, then a clean frame.
      for (int i = 0; i < 9; i++) begin
         frame_pad = (i == 0); a_pad = 1'b1; b_pad = 1'b0;
         tick();
      end
      chk("mid busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst a_out", a_out, 0);
      chk("rst b_out", b_out, 0);
      chk("rst op_valid", op_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst overrun", overrun, 0);
      tick(); tick();
      rst_n = 1'b1; frame_pad = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 10; i++) tick();
      chk("post-rst no valid", op_valid, 0);
      send_frame(16'h8001, 16'h7FFE, 1'b1, 1'b1, v15);
      chk("post-rst valid", op_valid, 1);
      chk("post-rst a_out", a_out, 16'h8001);
      chk("post-rst b_out", b_out, 16'h7FFE);
      tick();
      chk("post-rst one pair", n_acc - acc0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
